pc_seq: RTL

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with fetch handshake and trap.
// Ports: clk, rst_n, branch, ctrpc, reg_out, imm, instr_valid,
//   pc_ready, trap_clr -> pc, pc_valid, link, link_valid, trap,
//   trap_addr, instret. Macro PC_INSTRET_EN adds the instret counter.
module pc_seq #(
  parameter int          N         = 32,
  parameter logic [N-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         branch,
  input  logic [1:0]   ctrpc,
  input  logic [N-1:0] reg_out,
  input  logic [N-1:0] imm,
  input  logic         instr_valid,
  input  logic         pc_ready,
  input  logic         trap_clr,
  output logic [N-1:0] pc,
  output logic         pc_valid,
  output logic [N-1:0] link,
  output logic         link_valid,
  output logic         trap,
  output logic [N-1:0] trap_addr,
  output logic [N-1:0] instret
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    TRAP
  } state_t;

  localparam logic [N-1:0] FOUR = N'(4);

  state_t       state;
  logic         armed;
  logic [N-1:0] seq;
  logic [N-1:0] jsum;
  logic [N-1:0] tgt;
  logic         is_jal;
  logic         is_jalr;
  logic         use_off;
  logic         use_reg;
  logic         is_link;
  logic         mis;
  logic         commit;

  assign is_jal  = (ctrpc == 2'b10);
  assign is_jalr = (ctrpc == 2'b11);
  assign is_link = is_jal | is_jalr;
  // branch wins the target; JALR only when no branch
  assign use_off = branch | is_jal;
  assign use_reg = ~branch & is_jalr;

  always_comb begin
    seq  = pc + FOUR;
    jsum = reg_out + imm;
    tgt  = seq;
    unique case (1'b1)
      use_off: tgt = pc + imm;
      use_reg: tgt = {jsum[N-1:1], 1'b0};
      default: tgt = seq;
    endcase
  end

  assign mis    = |tgt[1:0];
  assign commit = (state == EXEC) & instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      pc         <= RESET_VEC;
      pc_valid   <= 1'b0;
      link       <= '0;
      link_valid <= 1'b0;
      trap       <= 1'b0;
      trap_addr  <= '0;
    end else begin
      link_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // first edge after release only arms
          armed <= 1'b1;
          if (armed) begin
            state    <= FETCH;
            pc_valid <= 1'b1;
          end
        end
        FETCH: begin
          if (pc_ready) begin
            state    <= EXEC;
            pc_valid <= 1'b0;
          end
        end
        EXEC: begin
          if (instr_valid) begin
            if (is_link) begin
              link       <= seq;
              link_valid <= 1'b1;
            end
            if (mis) begin
              trap      <= 1'b1;
              trap_addr <= tgt;
              state     <= TRAP;
            end else begin
              pc       <= tgt;
              pc_valid <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        TRAP: begin
          if (trap_clr) begin
            pc       <= RESET_VEC;
            trap     <= 1'b0;
            pc_valid <= 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PC_INSTRET_EN
  logic [N-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (commit && !mis) begin
      cnt <= cnt + N'(1);
    end
  end

  assign instret = cnt;
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign instret = '0;
`endif

endmodule
